// File: rtl/frame_writer_if.sv
// Raster pixel stream from the host side into the frame writer.
interface frame_writer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_ready;

    modport master (output in_valid, in_data, in_sof, input in_ready);
    modport slave  (input in_valid, in_data, in_sof, output in_ready);
endinterface

// File: rtl/frame_writer.sv
// Writes a raster-order pixel stream into column-major image memory
// (addr = col*IMG_HEIGHT + row) for the video generator.
module frame_writer #(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 400,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              rst,
    frame_writer_if.slave     pix,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state, state_nx;
    logic [COL_W-1:0]  col, col_cur, col_nx;
    logic [ROW_W-1:0]  row, row_cur, row_nx;
    logic [ADDR_W-1:0] addr, addr_cur, addr_nx;
    logic              accept, do_write, restart, last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // An SOF (or any beat in IDLE) always lands at pixel (0,0).
    always_comb begin
        if (state == IDLE || pix.in_sof) begin
            col_cur  = '0;
            row_cur  = '0;
            addr_cur = '0;
        end else begin
            col_cur  = col;
            row_cur  = row;
            addr_cur = addr;
        end
        last = (row_cur == ROW_W'(IMG_HEIGHT - 1)) && (col_cur == COL_W'(IMG_WIDTH - 1));
        if (col_cur == COL_W'(IMG_WIDTH - 1)) begin
            col_nx  = '0;
            row_nx  = row_cur + ROW_W'(1);
            addr_nx = ADDR_W'(row_cur) + ADDR_W'(1);
        end else begin
            col_nx  = col_cur + COL_W'(1);
            row_nx  = row_cur;
            addr_nx = addr_cur + ADDR_W'(IMG_HEIGHT);
        end
    end

    always_comb begin
        state_nx     = state;
        pix.in_ready = 1'b0;
        busy         = 1'b0;
        frame_done   = 1'b0;
        accept       = 1'b0;
        do_write     = 1'b0;
        restart      = 1'b0;
        case (state)
            IDLE: begin
                pix.in_ready = !rst;
                accept       = pix.in_valid && !rst;
                if (accept && pix.in_sof) begin
                    do_write = 1'b1;
                    state_nx = last ? DONE : WRITE;
                end
            end
            WRITE: begin
                pix.in_ready = !rst;
                busy         = 1'b1;
                accept       = pix.in_valid && !rst;
                if (accept) begin
                    do_write = 1'b1;
                    if (pix.in_sof) restart = 1'b1;
                    else if (last)  state_nx = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            sync_err <= 1'b0;
        end else begin
            wr_en    <= do_write;
            sync_err <= restart;
            if (do_write) begin
                wr_addr <= addr_cur;
                wr_data <= pix.in_data;
                col     <= col_nx;
                row     <= row_nx;
                addr    <= addr_nx;
            end
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: a 400x400 instance and a 4x3 instance.
module tb_frame_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    frame_writer_if ia();
    frame_writer_if ib();

    logic        wr_en_a, busy_a, frame_done_a, sync_err_a;
    logic [17:0] wr_addr_a;
    logic [7:0]  wr_data_a;
    logic        wr_en_b, busy_b, frame_done_b, sync_err_b;
    logic [17:0] wr_addr_b;
    logic [7:0]  wr_data_b;

    frame_writer dut_a (
        .clk(clk), .rst(rst_a), .pix(ia),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .frame_done(frame_done_a), .sync_err(sync_err_a)
    );

    frame_writer #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_W(18)) dut_b (
        .clk(clk), .rst(rst_b), .pix(ib),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .frame_done(frame_done_b), .sync_err(sync_err_b)
    );

    typedef struct {
        logic [17:0] addr;
        logic [7:0]  data;
        logic        sync;
        logic        done;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write word packed as {sync, done, data, addr}.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en_a === 1'b1) begin
            if (qa.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL a_unexpected_wr: got addr %0d data %0h expected no write", wr_addr_a, wr_data_a);
            end else begin
                e = qa.pop_front();
                chk("a_wr", {4'b0, sync_err_a, frame_done_a, wr_data_a, wr_addr_a},
                    {4'b0, e.sync, e.done, e.data, e.addr});
            end
        end else if (sync_err_a === 1'b1 || frame_done_a === 1'b1) begin
            chk("a_flag_without_wr", {30'b0, sync_err_a, frame_done_a}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (wr_en_b === 1'b1) begin
            if (qb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL b_unexpected_wr: got addr %0d data %0h expected no write", wr_addr_b, wr_data_b);
            end else begin
                e = qb.pop_front();
                chk("b_wr", {4'b0, sync_err_b, frame_done_b, wr_data_b, wr_addr_b},
                    {4'b0, e.sync, e.done, e.data, e.addr});
            end
        end else if (sync_err_b === 1'b1 || frame_done_b === 1'b1) begin
            chk("b_flag_without_wr", {30'b0, sync_err_b, frame_done_b}, 32'd0);
        end
    end

    task automatic beat_a(input logic [7:0] d, input logic sof, input bit wr,
                          input int addr, input bit sync, input bit done);
        ia.in_valid = 1'b1;
        ia.in_data  = d;
        ia.in_sof   = sof;
        if (wr) qa.push_back('{18'(addr), d, sync, done});
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        ia.in_sof   = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] d, input logic sof, input bit wr,
                          input int addr, input bit sync, input bit done);
        ib.in_valid = 1'b1;
        ib.in_data  = d;
        ib.in_sof   = sof;
        if (wr) qb.push_back('{18'(addr), d, sync, done});
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        ib.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_sof = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_sof = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle(2);
        chk("a_rst_ready", {31'b0, ia.in_ready}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("a_rst_wr_en", {31'b0, wr_en_a}, 32'd0);
        chk("a_rst_busy", {31'b0, busy_a}, 32'd0);
        chk("a_idle_ready", {31'b0, ia.in_ready}, 32'd1);

        // Non-SOF beats in IDLE are dropped.
        for (int i = 0; i < 5; i++) begin
            beat_a(8'h55, 1'b0, 1'b0, 0, 1'b0, 1'b0);
            chk("a_drop_busy", {31'b0, busy_a}, 32'd0);
            chk("a_drop_ready", {31'b0, ia.in_ready}, 32'd1);
        end

        // Frame start through the first row wrap (pixel 400 -> addr 1).
        for (int i = 0; i <= 400; i++) begin
            logic [7:0] d;
            d = (i < 4) ? 8'(8'h10 + i) : 8'(i);
            if (i >= 4 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            beat_a(d, i == 0, 1'b1, (i % 400) * 400 + i / 400, 1'b0, 1'b0);
            if (i == 0) chk("a_busy_after_sof", {31'b0, busy_a}, 32'd1);
        end

        // SOF mid-frame restarts; a second SOF after 7 pixels does the same.
        beat_a(8'h20, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        for (int i = 1; i < 7; i++) beat_a(8'(8'h20 + i), 1'b0, 1'b1, i * 400, 1'b0, 1'b0);
        beat_a(8'hAA, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        beat_a(8'hAB, 1'b0, 1'b1, 400, 1'b0, 1'b0);
        chk("a_busy_after_restart", {31'b0, busy_a}, 32'd1);

        // One-cycle reset mid-frame.
        beat_a(8'h01, 1'b0, 1'b1, 800, 1'b0, 1'b0);
        rst_a = 1'b1;
        #1;
        chk("a_ready_in_rst", {31'b0, ia.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        chk("a_post_rst_outs",
            {3'b0, wr_en_a, busy_a, frame_done_a, sync_err_a, wr_data_a, wr_addr_a}, 32'd0);
        beat_a(8'h77, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("a_post_rst_drop_busy", {31'b0, busy_a}, 32'd0);
        beat_a(8'h78, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        chk("a_post_rst_sof_busy", {31'b0, busy_a}, 32'd1);

        // 4x3 frame back-to-back: 0,3,6,9,1,4,7,10,2,5,8,11.
        for (int i = 0; i < 12; i++)
            beat_b(8'(i), i == 0, 1'b1, (i % 4) * 3 + i / 4, 1'b0, i == 11);
        chk("b_done_ready", {31'b0, ib.in_ready}, 32'd0);
        chk("b_done_busy", {31'b0, busy_b}, 32'd0);
        chk("b_done_pulse", {31'b0, frame_done_b}, 32'd1);
        idle(1);
        chk("b_idle_ready", {31'b0, ib.in_ready}, 32'd1);
        chk("b_idle_done", {31'b0, frame_done_b}, 32'd0);

        // Same frame with random gaps.
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 2));
            beat_b(8'(8'h80 + i), i == 0, 1'b1, (i % 4) * 3 + i / 4, 1'b0, i == 11);
        end
        chk("b_gap_done_pulse", {31'b0, frame_done_b}, 32'd1);
        idle(1);

        // SOF on the final pixel restarts instead of completing.
        for (int i = 0; i < 11; i++)
            beat_b(8'(8'hC0 + i), i == 0, 1'b1, (i % 4) * 3 + i / 4, 1'b0, 1'b0);
        beat_b(8'hEE, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        chk("b_final_sof_busy", {31'b0, busy_b}, 32'd1);
        beat_b(8'hEF, 1'b0, 1'b1, 3, 1'b0, 1'b0);

        idle(3);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Fills the 8-bit grayscale image memory scanned by the VGA video generator.
- Accepts a raster-order pixel stream (row 0 left-to-right, then row 1, ...) from the host/UART side over a valid/ready handshake.
- Writes each pixel into the column-major layout the video generator reads: address = col*IMG_HEIGHT + row.
- Flags frame completion and stream sync errors.

Parameters:
IMG_WIDTH, 400, pixels per row (columns)
IMG_HEIGHT, 400, rows per frame
ADDR_W, 18, memory address width; IMG_WIDTH*IMG_HEIGHT must be at most 2^ADDR_W

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel beat valid
in_data  in  8  grayscale pixel value
in_sof  in  1  marks first pixel of a frame; qualified by in_valid
in_ready  out  1  block accepts a beat this cycle
wr_en  out  1  memory write strobe
wr_addr  out  ADDR_W  memory write address
wr_data  out  8  memory write data
busy  out  1  frame in progress (state WRITE)
frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
sync_err  out  1  one-cycle pulse on an SOF received mid-frame

Behaviour:
- Beat accepted when in_valid && in_ready.
- Reset values: in_ready=0 during rst; all other outputs 0 (wr_en, wr_addr, wr_data, busy, frame_done, sync_err). State returns to IDLE. Counters row=0, col=0, base address=0.
- Reset mid-frame abandons the frame with no frame_done. The next frame requires a new SOF.
- States:
  - IDLE: in_ready=1. Accepted beat with in_sof=1 is written as pixel (row 0, col 0); go to WRITE. Accepted beat with in_sof=0 is silently dropped (no wr_en).
  - WRITE: in_ready=1, busy=1. Each accepted beat is written at the current (row, col). The beat at (IMG_HEIGHT-1, IMG_WIDTH-1) goes to DONE.
  - DONE: in_ready=0, busy=0. Lasts exactly one cycle, then goes to IDLE.
- Write timing: beat accepted at cycle N gives wr_en=1 with wr_addr/wr_data at cycle N+1, for exactly one cycle. wr_en is low in any cycle following no accepted, non-dropped beat.
- frame_done asserts in the cycle DONE is occupied, i.e. the same cycle as the final wr_en.
- Address generation uses no multiplier:
  - Keep row, col and the running address.
  - Within a row, the next address is the current address + IMG_HEIGHT and col increments.
  - At col=IMG_WIDTH-1, col wraps to 0, row increments, and the next address = new row (col 0).
- SOF during WRITE:
  - sync_err pulses at N+1.
  - The partial frame is abandoned with no frame_done.
  - The beat is written at address 0 as pixel (0,0) of a new frame; state stays WRITE.
- in_sof on the final pixel of a frame is treated as an SOF mid-frame (restart rule above).
- Gaps (in_valid=0) are legal anywhere and hold all counters.
- in_data is captured only on accepted beats.
- Address arithmetic is unsigned ADDR_W bits. The maximum address is IMG_WIDTH*IMG_HEIGHT-1 = 159999 at defaults; no wrap past it.

Test Plan:
- Reset, then in_valid=1 with in_sof=0, data 0x55 for 5 cycles -> no wr_en, busy=0, in_ready=1.
- SOF beat 0x10, then 3 beats 0x11..0x13 back-to-back -> wr_addr 0, 400, 800, 1200 at cycles N+1..N+4; wr_data 0x10..0x13; busy=1.
- Full 160000-pixel frame at defaults with random valid gaps -> pixel index 400 (row 1, col 0) writes addr 1; final beat writes addr 159999 with frame_done=1 in that cycle; in_ready=0 for one cycle, then IDLE.
- IMG_WIDTH=4, IMG_HEIGHT=3, pixels 0..11 -> address sequence 0,3,6,9,1,4,7,10,2,5,8,11; one frame_done.
- Mid-frame SOF after 7 pixels (data 0xAA) -> sync_err pulse, wr_addr=0, wr_data=0xAA; the following beat writes addr 400; no frame_done for the aborted frame.
- rst asserted for 1 cycle mid-frame -> all outputs 0 the next cycle; a non-SOF beat afterwards is dropped; an SOF beat writes addr 0.
